// File: rtl/tdc_calib_if.sv
// Purpose : control, parameter and signal bundle between a calibration host and tdc_calib_seq.
// Latency : none, wires only.
// Backpressure: none; start/abort are level requests sampled by the sequencer, done_o is a one-cycle pulse.
// Ports   : host-driven inputs start_i, abort_i, chan_mask_i, half_period_i, n_pulses_i, signal_i;
//           sequencer-driven outputs tdc_signal_o, calib_active_o, busy_o, done_o, aborted_o,
//           pulse_count_o, test_clk_o. The master modport is the host side and the slave modport is the sequencer side.
interface tdc_calib_if #(
    parameter int G_CHANNELS  = 2,
    parameter int G_CNT_WIDTH = 16
);
    logic                   start_i;
    logic                   abort_i;
    logic [G_CHANNELS-1:0]  chan_mask_i;
    logic [G_CNT_WIDTH-1:0] half_period_i;
    logic [G_CNT_WIDTH-1:0] n_pulses_i;
    logic [G_CHANNELS-1:0]  signal_i;

    logic [G_CHANNELS-1:0]  tdc_signal_o;
    logic [G_CHANNELS-1:0]  calib_active_o;
    logic                   busy_o;
    logic                   done_o;
    logic                   aborted_o;
    logic [G_CNT_WIDTH-1:0] pulse_count_o;
    logic                   test_clk_o;

    modport master (
        output start_i, abort_i, chan_mask_i, half_period_i, n_pulses_i, signal_i,
        input  tdc_signal_o, calib_active_o, busy_o, done_o, aborted_o, pulse_count_o, test_clk_o
    );

    modport slave (
        input  start_i, abort_i, chan_mask_i, half_period_i, n_pulses_i, signal_i,
        output tdc_signal_o, calib_active_o, busy_o, done_o, aborted_o, pulse_count_o, test_clk_o
    );
endinterface

// File: rtl/tdc_calib_seq.sv
// Purpose : TDC calibration sequencer. It muxes a square-wave calibration burst, framed by guard
//           intervals, onto the selected TDC channels. All other channels pass signal_i through.
// Latency : every output is registered. Passthrough has 1 cycle of delay. The burst begins on the
//           cycle after an accepted start.
// Backpressure: none. start_i is only sampled in IDLE and is ignored while busy_o is high.
//           abort_i ends the burst early.
// Ports   : clk_i (rising edge), reset_i (asynchronous, active high), bus (tdc_calib_if.slave).
// Option  : define TDC_TEST_CLK_EN to build a free-running divider. test_clk_o is then the MSB of
//           that divider. Without the macro, test_clk_o is tied to 0.
module tdc_calib_seq #(
    parameter int G_CHANNELS      = 2,
    parameter int G_CNT_WIDTH     = 16,
    parameter int G_GUARD         = 4,
    parameter int G_TEST_DIV_BITS = 19
) (
    input  logic         clk_i,
    input  logic         reset_i,
    tdc_calib_if.slave   bus
);

    // Elaboration-time parameter sanity checks.
    if (G_GUARD < 1) begin : g_guard_chk
        $error("G_GUARD must be at least 1");
    end
    if (G_TEST_DIV_BITS < 1) begin : g_div_chk
        $error("G_TEST_DIV_BITS must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_GUARD_IN,
        S_BURST,
        S_GUARD_OUT,
        S_DONE
    } state_t;

    localparam logic [G_CNT_WIDTH-1:0] CNT_ONE    = G_CNT_WIDTH'(1);
    localparam logic [G_CNT_WIDTH-1:0] GUARD_LAST = G_CNT_WIDTH'(G_GUARD - 1);

    state_t                 state_q,   state_d;
    logic [G_CNT_WIDTH-1:0] cnt_q,     cnt_d;      // cycles spent in the current guard or half-phase
    logic                   hi_q,      hi_d;       // burst phase: 1 = high half, 0 = low half
    logic [G_CHANNELS-1:0]  mask_q,    mask_d;
    logic [G_CNT_WIDTH-1:0] half_q,    half_d;
    logic [G_CNT_WIDTH-1:0] npulse_q,  npulse_d;
    logic [G_CNT_WIDTH-1:0] pcnt_q,    pcnt_d;
    logic                   aborted_q, aborted_d;

    logic                   busy_q,    busy_d;
    logic                   done_q,    done_d;
    logic [G_CHANNELS-1:0]  active_q,  active_d;
    logic [G_CHANNELS-1:0]  tdc_q,     tdc_d;
    logic                   sel_d;
    logic                   burst_hi_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        mask_d    = mask_q;
        half_d    = half_q;
        npulse_d  = npulse_q;
        pcnt_d    = pcnt_q;
        aborted_d = aborted_q;

        case (state_q)
            S_IDLE: begin
                // If abort and start arrive together, abort wins and the start is dropped.
                if (bus.start_i && !bus.abort_i) begin
                    mask_d    = bus.chan_mask_i;
                    half_d    = (bus.half_period_i == '0) ? CNT_ONE : bus.half_period_i;
                    npulse_d  = bus.n_pulses_i;
                    pcnt_d    = '0;
                    aborted_d = 1'b0;
                    cnt_d     = '0;
                    hi_d      = 1'b0;
                    // An empty burst skips straight to DONE without touching any channel.
                    if (bus.n_pulses_i == '0 || bus.chan_mask_i == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_GUARD_IN;
                    end
                end
            end

            S_GUARD_IN: begin
                if (bus.abort_i) begin
                    state_d   = S_GUARD_OUT;
                    cnt_d     = '0;
                    hi_d      = 1'b0;
                    aborted_d = 1'b1;
                end else if (cnt_q == GUARD_LAST) begin
                    state_d = S_BURST;
                    cnt_d   = '0;
                    hi_d    = 1'b1;
                    pcnt_d  = pcnt_q + CNT_ONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_BURST: begin
                if (bus.abort_i) begin
                    state_d   = S_GUARD_OUT;
                    cnt_d     = '0;
                    hi_d      = 1'b0;
                    aborted_d = 1'b1;
                end else if (cnt_q == half_q - CNT_ONE) begin
                    cnt_d = '0;
                    if (hi_q) begin
                        hi_d = 1'b0;
                    end else if (pcnt_q == npulse_q) begin
                        // The low half of the final pulse has completed. The counter stops
                        // here and cannot wrap.
                        state_d = S_GUARD_OUT;
                    end else begin
                        hi_d   = 1'b1;
                        pcnt_d = pcnt_q + CNT_ONE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_GUARD_OUT: begin
                if (cnt_q == GUARD_LAST) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Output registers are loaded from next-state values, so each output reflects the state it is in.
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
        sel_d      = (state_d == S_GUARD_IN) || (state_d == S_BURST) || (state_d == S_GUARD_OUT);
        active_d   = sel_d ? mask_d : '0;
        burst_hi_d = (state_d == S_BURST) && hi_d;
        tdc_d      = bus.signal_i;
        for (int c = 0; c < G_CHANNELS; c++) begin
            if (active_d[c]) begin
                tdc_d[c] = burst_hi_d;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            hi_q      <= 1'b0;
            mask_q    <= '0;
            half_q    <= '0;
            npulse_q  <= '0;
            pcnt_q    <= '0;
            aborted_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            active_q  <= '0;
            tdc_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            mask_q    <= mask_d;
            half_q    <= half_d;
            npulse_q  <= npulse_d;
            pcnt_q    <= pcnt_d;
            aborted_q <= aborted_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            active_q  <= active_d;
            tdc_q     <= tdc_d;
        end
    end

    assign bus.tdc_signal_o   = tdc_q;
    assign bus.calib_active_o = active_q;
    assign bus.busy_o         = busy_q;
    assign bus.done_o         = done_q;
    assign bus.aborted_o      = aborted_q;
    assign bus.pulse_count_o  = pcnt_q;

`ifdef TDC_TEST_CLK_EN
    logic [G_TEST_DIV_BITS-1:0] div_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    assign bus.test_clk_o = div_q[G_TEST_DIV_BITS-1];
`else
    assign bus.test_clk_o = 1'b0;
`endif

endmodule

// File: doc/tdc_calib_seq.md
TDC_CALIB_SEQ -- requirements
Module: tdc_calib_seq

Interface
REQ-001 SHALL have parameter G_CHANNELS, default 2, number of TDC input channels.
REQ-002 SHALL have parameter G_CNT_WIDTH, default 16, width of period and pulse-count fields.
REQ-003 SHALL have parameter G_GUARD, default 4, guard cycles (at least 1) before and after a burst.
REQ-004 SHALL have parameter G_TEST_DIV_BITS, default 19, test-clock divider width.
REQ-005 SHALL have port clk_i, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset_i, input, 1, reset, asynchronous and active-high.
REQ-007 SHALL have port start_i, input, 1, burst request, sampled in IDLE only.
REQ-008 SHALL have port abort_i, input, 1, terminate burst.
REQ-009 SHALL have port chan_mask_i, input, G_CHANNELS, channels to calibrate.
REQ-010 SHALL have port half_period_i, input, G_CNT_WIDTH, calibration half-period in cycles.
REQ-011 SHALL have port n_pulses_i, input, G_CNT_WIDTH, pulses per burst.
REQ-012 SHALL have port signal_i, input, G_CHANNELS, external detector signals.
REQ-013 SHALL have port tdc_signal_o, output, G_CHANNELS, muxed signal to TDC.
REQ-014 SHALL have port calib_active_o, output, G_CHANNELS, per-channel calibration-select flags.
REQ-015 SHALL have port busy_o, output, 1, high in every state except IDLE.
REQ-016 SHALL have port done_o, output, 1, one-cycle completion pulse.
REQ-017 SHALL have port aborted_o, output, 1, last burst was aborted.
REQ-018 SHALL have port pulse_count_o, output, G_CNT_WIDTH, rising calibration edges issued in the current or last burst.
REQ-019 SHALL have port test_clk_o, output, 1, divided test clock.

Function
REQ-020 SHALL implement FSM states IDLE, GUARD_IN, BURST, GUARD_OUT, DONE; all outputs registered.
REQ-021 IDLE: start_i=1 and abort_i=0 SHALL latch mask, half-period and pulse count and go to GUARD_IN; start_i while busy_o=1 SHALL be ignored.
REQ-022 A start with n_pulses_i=0 or chan_mask_i=0 SHALL go directly to DONE with no channel switched; half_period_i=0 SHALL be treated as 1.
REQ-023 GUARD_IN SHALL assert calib_active_o on masked channels, drive them low for G_GUARD cycles, then enter BURST.
REQ-024 BURST SHALL drive masked channels high for half-period cycles, then low for half-period cycles, repeating; pulse_count_o SHALL increment on each low-to-high transition.
REQ-025 After the low phase of pulse n_pulses, BURST SHALL go to GUARD_OUT: G_GUARD cycles low with channels still selected, then DONE.
REQ-026 DONE SHALL last 1 cycle with done_o=1, SHALL clear calib_active_o, then return to IDLE.
REQ-027 Unmasked channels, and all channels outside GUARD_IN through GUARD_OUT, SHALL output signal_i delayed by exactly 1 register stage.
REQ-028 abort_i in GUARD_IN or BURST SHALL force masked outputs low on the next cycle, enter GUARD_OUT and set aborted_o; abort_i in GUARD_OUT or DONE SHALL have no effect.
REQ-029 start_i and abort_i together in IDLE: abort SHALL win and no burst SHALL start.
REQ-030 aborted_o SHALL clear on the next accepted start; pulse_count_o SHALL clear on accepted start and hold after DONE.
REQ-031 The pulse counter SHALL NOT wrap: bursts end at n_pulses_i, which is at most 2^G_CNT_WIDTH-1.

Reset
REQ-032 reset_i SHALL asynchronously force IDLE and reset every output and counter to 0, including mid-burst; tdc_signal_o SHALL be 0 until the first clock after release.

Configuration
REQ-033 With macro TDC_TEST_CLK_EN defined: a free-running G_TEST_DIV_BITS counter SHALL run and test_clk_o SHALL equal its MSB (period 2^G_TEST_DIV_BITS cycles).
REQ-034 Without TDC_TEST_CLK_EN: no divider logic SHALL be built and test_clk_o SHALL be constant 0.

Verification
REQ-035 Start, mask=2'b01, half=3, n=4 -> ch0 high 3 and low 3 cycles, 4 times; pulse_count_o=4; ch1 follows signal_i; done_o 1 cycle after 4+24+4 burst cycles.
REQ-036 abort_i in cycle 10 of the same burst -> ch0 low next cycle; 4 guard cycles; done_o=1; aborted_o=1; pulse_count_o=2.
REQ-037 start with n=0 -> done_o one cycle later; calib_active_o never set; aborted_o=0.
REQ-038 start during BURST -> ignored; latched parameters unchanged; burst completes normally.
REQ-039 reset_i pulsed mid-BURST -> all outputs 0 immediately; busy_o=0; a new start works normally.
REQ-040 TDC_TEST_CLK_EN defined with G_TEST_DIV_BITS=4 -> test_clk_o toggles every 8 cycles; macro undefined -> test_clk_o stays 0.
